// File: rtl/adaptive_weight_streamer.sv
// Snapshots a live weight bus on request and streams the frozen copy out one
// word per ready/valid handshake, index 0 first. Back-to-back restart on the last word.
//
// state  | meaning
// IDLE   | no stream active, m_valid low, waiting for snap_req
// STREAM | presenting r_snap[r_index], advancing on each accepted word
module adaptive_weight_streamer #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [TAPS-1:0][WIDTH-1:0]  weights,
    input  logic                        snap_req,
    output logic [WIDTH-1:0]            m_data,
    output logic [$clog2(TAPS)-1:0]     m_index,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last,
    output logic                        busy,
    output logic                        req_dropped
);

    localparam int IW = $clog2(TAPS);
    localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [TAPS-1:0][WIDTH-1:0] r_snap;
    logic [IW-1:0]              r_index;
    logic [IW-1:0]              w_index_nxt;
    logic                       r_dropped;
    logic                       w_dropped_nxt;
    logic                       w_capture;
    logic                       w_xfer;
    logic                       w_at_last;

    // The name says "n" but this reset is active-high.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state   <= S_IDLE;
            r_snap    <= '0;
            r_index   <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_index   <= w_index_nxt;
            r_dropped <= w_dropped_nxt;
            if (w_capture) begin
                r_snap <= weights;
            end
        end
    end

    assign w_xfer    = (r_state == S_STREAM) && m_ready;
    assign w_at_last = (r_index == LAST_IDX);

    always_comb begin
        w_state_nxt   = r_state;
        w_index_nxt   = r_index;
        w_dropped_nxt = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (snap_req) begin
                    w_capture   = 1'b1;
                    w_index_nxt = '0;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_xfer && w_at_last) begin
                    // A request landing on the final transfer restarts with no bubble.
                    w_index_nxt = '0;
                    if (snap_req) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_dropped_nxt = snap_req;
                    if (w_xfer) begin
                        w_index_nxt = r_index + IW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_index_nxt = '0;
            end
        endcase
    end

    assign m_valid     = (r_state == S_STREAM);
    assign busy        = m_valid;
    assign m_index     = r_index;
    assign m_data      = r_snap[r_index];
    assign m_last      = m_valid && w_at_last;
    assign req_dropped = r_dropped;

endmodule
